// File: rtl/bus_transaction_arbiter.sv
// bus_transaction_arbiter
//
// Shares one 32-bit external memory bus between two requesters. Port 0 is
// the CPU load/store/fetch controller and port 1 is the DMA/debug master.
// Each request carries a 4-bit transaction code. The arbiter turns the code
// into a single bus cycle with a write flag and byte enables. It waits for
// busAck or aborts after TIMEOUT_CYCLES. It then returns done, error and
// read data to the port that won arbitration.
//
// Ports:
//   clk, reset          system clock, asynchronous active-high reset
//   req[1:0]            per-port request, held until that port's done pulse
//   transaction0/1      per-port transaction code
//   address0/1          per-port address
//   writeData0/1        per-port write data
//   done[1:0]           per-port one-cycle completion pulse
//   error[1:0]          per-port error flag, valid only with done
//   readData            last captured read data, valid with done
//   busCycle            bus cycle active
//   busWrite            1 = write cycle
//   busByteEnable       active byte lanes
//   busAddress          bus address
//   busWriteData        bus write data
//   busAck              slave completion
//   busReadData         slave read data

module bus_transaction_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned ADDR_WIDTH     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            req,
    input  logic [3:0]            transaction0,
    input  logic [3:0]            transaction1,
    input  logic [ADDR_WIDTH-1:0] address0,
    input  logic [ADDR_WIDTH-1:0] address1,
    input  logic [31:0]           writeData0,
    input  logic [31:0]           writeData1,
    output logic [1:0]            done,
    output logic [1:0]            error,
    output logic [31:0]           readData,
    output logic                  busCycle,
    output logic                  busWrite,
    output logic [3:0]            busByteEnable,
    output logic [ADDR_WIDTH-1:0] busAddress,
    output logic [31:0]           busWriteData,
    input  logic                  busAck,
    input  logic [31:0]           busReadData
);

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        RESP
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t                state_q, state_d;
    logic                  grant_q, grant_d;
    logic                  last_grant_q, last_grant_d;
    logic [7:0]            timer_q, timer_d;
    logic                  is_read_q, is_read_d;
    logic [1:0]            done_q, done_d;
    logic [1:0]            error_q, error_d;
    logic [31:0]           read_data_q, read_data_d;
    logic                  bus_cycle_q, bus_cycle_d;
    logic                  bus_write_q, bus_write_d;
    logic [3:0]            bus_be_q, bus_be_d;
    logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
    logic [31:0]           bus_wdata_q, bus_wdata_d;

    logic                  grant_sel;
    logic [3:0]            sel_code;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [31:0]           sel_wdata;
    logic                  dec_valid;
    logic                  dec_write;
    logic [3:0]            dec_be;

    // Pick the winning port and decode its transaction code. On a tie the
    // port that did not win last time is chosen.
    always_comb begin
        grant_sel = (&req) ? ~last_grant_q : req[1];
        sel_code  = grant_sel ? transaction1 : transaction0;
        sel_addr  = grant_sel ? address1 : address0;
        sel_wdata = grant_sel ? writeData1 : writeData0;

        dec_valid = 1'b1;
        dec_write = 1'b1;
        dec_be    = 4'b0000;
        case (sel_code)
            4'd1:    begin dec_write = 1'b0; dec_be = 4'b1111; end
            4'd2:    dec_be = 4'b0001;
            4'd3:    dec_be = 4'b0010;
            4'd4:    dec_be = 4'b0100;
            4'd5:    dec_be = 4'b1000;
            4'd6:    dec_be = 4'b0011;
            4'd7:    dec_be = 4'b1100;
            4'd8:    dec_be = 4'b1111;
            default: begin dec_valid = 1'b0; dec_write = 1'b0; end
        endcase
    end

    // Next-state logic. done and error are set on the transition into RESP,
    // so they appear as registered outputs during the RESP cycle. An ack
    // takes priority over the timeout abort in the same cycle.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        timer_d      = timer_q;
        is_read_d    = is_read_q;
        done_d       = 2'b00;
        error_d      = 2'b00;
        read_data_d  = read_data_q;
        bus_cycle_d  = bus_cycle_q;
        bus_write_d  = bus_write_q;
        bus_be_d     = bus_be_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;

        case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    grant_d   = grant_sel;
                    timer_d   = 8'd0;
                    is_read_d = (sel_code == 4'd1);
                    if (dec_valid) begin
                        state_d     = BUS;
                        bus_cycle_d = 1'b1;
                        bus_write_d = dec_write;
                        bus_be_d    = dec_be;
                        bus_addr_d  = sel_addr;
                        bus_wdata_d = sel_wdata;
                    end else begin
                        state_d            = RESP;
                        done_d[grant_sel]  = 1'b1;
                        error_d[grant_sel] = (sel_code != 4'd0);
                    end
                end
            end
            BUS: begin
                if (busAck) begin
                    state_d          = RESP;
                    bus_cycle_d      = 1'b0;
                    done_d[grant_q]  = 1'b1;
                    if (is_read_q) begin
                        read_data_d = busReadData;
                    end
                end else if (timer_q == TIMEOUT_LAST) begin
                    state_d          = RESP;
                    bus_cycle_d      = 1'b0;
                    done_d[grant_q]  = 1'b1;
                    error_d[grant_q] = 1'b1;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            RESP: begin
                last_grant_d = grant_q;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All state and outputs are registered here. Reset drops busCycle,
    // done and error immediately. lastGrant resets to 1 so port 0 wins
    // the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            timer_q      <= 8'd0;
            is_read_q    <= 1'b0;
            done_q       <= 2'b00;
            error_q      <= 2'b00;
            read_data_q  <= 32'd0;
            bus_cycle_q  <= 1'b0;
            bus_write_q  <= 1'b0;
            bus_be_q     <= 4'b0000;
            bus_addr_q   <= '0;
            bus_wdata_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            timer_q      <= timer_d;
            is_read_q    <= is_read_d;
            done_q       <= done_d;
            error_q      <= error_d;
            read_data_q  <= read_data_d;
            bus_cycle_q  <= bus_cycle_d;
            bus_write_q  <= bus_write_d;
            bus_be_q     <= bus_be_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
        end
    end

    assign done          = done_q;
    assign error         = error_q;
    assign readData      = read_data_q;
    assign busCycle      = bus_cycle_q;
    assign busWrite      = bus_write_q;
    assign busByteEnable = bus_be_q;
    assign busAddress    = bus_addr_q;
    assign busWriteData  = bus_wdata_q;

endmodule

// File: doc/bus_transaction_arbiter.md
Name: bus_transaction_arbiter

Overview:
- Shares the single 32-bit external memory bus between two requesters: port 0 (CPU load/store/fetch controller) and port 1 (DMA/debug master).
- Accepts encoded transaction codes and issues one bus cycle at a time, with round-robin arbitration, ack handshake and timeout abort.
- Converts each code into bus write strobe and byte enables, and returns read data, done and error to the winning requester.
- Sits between the CPU controller's registered transaction output and the system bus interface.

Parameters:
- TIMEOUT_CYCLES, 255, bus cycles to wait for busAck before aborting; range 1..255, stored in an 8-bit counter.
- ADDR_WIDTH, 32, width of the address ports.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- req  input  2  per-port request; held high until that port's done pulse
- transaction0  input  4  port 0 transaction code
- transaction1  input  4  port 1 transaction code
- address0  input  ADDR_WIDTH  port 0 address
- address1  input  ADDR_WIDTH  port 1 address
- writeData0  input  32  port 0 write data
- writeData1  input  32  port 1 write data
- done  output  2  per-port one-cycle completion pulse
- error  output  2  per-port error flag; valid only with done
- readData  output  32  captured read data; valid with done
- busCycle  output  1  bus cycle active
- busWrite  output  1  1 = write
- busByteEnable  output  4  byte lanes
- busAddress  output  ADDR_WIDTH  bus address
- busWriteData  output  32  bus write data
- busAck  input  1  slave completion
- busReadData  input  32  slave read data

Behaviour:
- Transaction codes (codes not listed below are invalid):
  - 0 NO_OP
  - 1 READ: be=1111, write=0
  - 2..5 WRITE_BYTE0..3: be=0001/0010/0100/1000, write=1
  - 6 WRITE_WORD0: be=0011, write=1
  - 7 WRITE_WORD1: be=1100, write=1
  - 8 WRITE_DWORD: be=1111, write=1
- Reset values: all outputs 0, state IDLE, lastGrant=1 (so port 0 wins the first tie).
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - If any req is set, grant it. If both are set, grant the port other than lastGrant.
  - Latch grant, code, address and data. Drive all bus outputs registered next cycle. Go to BUS. Clear timeout counter.
  - If the granted code is NO_OP or invalid, skip the bus: busCycle stays 0, go to RESP. Error=0 for NO_OP; error=1 for invalid codes.
- BUS:
  - busCycle=1; busWrite, busByteEnable, busAddress and busWriteData are held stable.
  - On busAck: capture busReadData (reads only), drop busCycle next cycle, go to RESP.
  - Otherwise increment the counter. When counter==TIMEOUT_CYCLES-1 with no ack, abort: busCycle drops next cycle, error=1, go to RESP.
  - An ack arriving in the same cycle as the timeout wins; no error is flagged.
- RESP:
  - One cycle: done[grant]=1, error[grant] and readData valid. lastGrant=grant. Go to IDLE.
  - readData holds its value until the next read completes.
- Latency: req high in cycle N → busCycle in N+1. busAck in cycle M → done in M+1. Minimum round trip is 3 cycles when ack arrives in the first BUS cycle.
- The requester drops req in the cycle after done. Req seen again in IDLE starts a new transaction. A req still high on the cycle done pulses is not re-sampled until IDLE.
- Request inputs are ignored outside IDLE. A req deasserted mid-transaction does not abort the bus cycle; done still pulses.
- busAck outside BUS is ignored.
- Asynchronous reset mid-BUS drops busCycle immediately. No done pulse is generated.

Test Plan:
- Port 0 only, READ at 0x1000, busAck 2 cycles after busCycle, busReadData=0xDEADBEEF → busCycle in N+1, be=1111, write=0; done[0] with readData=0xDEADBEEF, error=0.
- Port 1 WRITE_BYTE2, address 0x22, data 0x00AB0000, immediate ack → be=0100, write=1, busWriteData=0x00AB0000; done[1] 3 cycles after req.
- Both ports request from reset, 4 back-to-back transactions each → grants alternate 0,1,0,1…; no port is granted twice in a row while the other waits.
- TIMEOUT_CYCLES=4, no ack → busCycle high exactly 4 cycles; done[0] with error[0]=1. Repeat with ack on the 4th cycle → error=0.
- Codes 0 and 0xF → no busCycle; done pulses after 2 cycles; error=0 for code 0, error=1 for 0xF.
- Assert reset during BUS → busCycle, done and error are 0 immediately. After release, a new port 0 request is granted.
